// File: rtl/weight_loader_pkg.sv
// weight_loader_pkg: shared widths, loader states and per-layer weight depths
package weight_loader_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int NUM_WORDS_IN = 784;
  localparam int NUM_WORDS_H1 = 128;
  localparam int NUM_WORDS_H2 = 64;
  localparam int NUM_WORDS_OUT = 10;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
endpackage

// File: rtl/weight_ram.sv
// weight_ram: sync-write / async-read word storage, out-of-range reads return 0
module weight_ram
  import weight_loader_pkg::*;
#(
  parameter int NUM_WORDS = 784,
  parameter int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_add,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [31:0]       read_add,
  output logic [WORD_W-1:0] write_out
);
  logic [WORD_W-1:0] mem [NUM_WORDS];
  always_ff @(posedge clk)
    if (we) mem[wr_add] <= wr_data;
  assign write_out = (read_add < 32'(NUM_WORDS)) ? mem[read_add[AW-1:0]] : '0;
endmodule

// File: rtl/weight_loader.sv
// weight_loader: assembles a little-endian byte stream into 32-bit words and loads them into weight_ram
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_IN,
  parameter int CNT_W = $clog2(NUM_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [CNT_W-1:0]  words_loaded,
  input  logic [31:0]       read_add,
  output logic [WORD_W-1:0] write_out
);
  localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  state_t state, state_nx;
  logic [1:0] byte_cnt;
  logic [23:0] asm_q;
  logic accept, we, last, enter_load;
  assign in_ready = state == LOAD;
  assign busy = state == LOAD;
  // abort takes precedence over a byte arriving in the same cycle
  assign accept = in_valid && in_ready && !abort;
  assign we = accept && byte_cnt == 2'd3;
  assign last = we && words_loaded == CNT_W'(NUM_WORDS - 1);
  always_comb begin
    state_nx = state;
    if (state == LOAD) state_nx = abort ? IDLE : last ? DONE : LOAD;
    else state_nx = abort ? IDLE : start ? LOAD : state;
  end
  assign enter_load = state != LOAD && state_nx == LOAD;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      byte_cnt <= '0;
      asm_q <= '0;
      words_loaded <= '0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (enter_load) begin
        byte_cnt <= '0;
        asm_q <= '0;
        words_loaded <= '0;
        done <= 1'b0;
        overrun <= 1'b0;
      end else begin
        if (state == LOAD && abort) begin
          byte_cnt <= '0;
          asm_q <= '0;
        end
        if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
          asm_q <= {byte_cnt == 2'd2 ? in_byte : asm_q[23:16],
                    byte_cnt == 2'd1 ? in_byte : asm_q[15:8],
                    byte_cnt == 2'd0 ? in_byte : asm_q[7:0]};
        end
        if (we) words_loaded <= words_loaded + 1'b1;
        if (last) done <= 1'b1;
        if (state == DONE && abort) done <= 1'b0;
        if (state == DONE && in_valid) overrun <= 1'b1;
      end
    end
  weight_ram #(.NUM_WORDS(NUM_WORDS), .AW(AW)) u_ram (
    .clk(clk),
    .we(we),
    .wr_add(words_loaded[AW-1:0]),
    .wr_data({in_byte, asm_q}),
    .read_add(read_add),
    .write_out(write_out)
  );
endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Writer-side counterpart of the read-only weight memory.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver.
- Assembles the bytes little-endian into 32-bit weight words and writes them sequentially into internal storage of NUM_WORDS entries.
- Exposes the same combinational read port (read_add to write_out) to the neuron datapath, so the network loads weights at runtime instead of from a file.

Parameters:
- NUM_WORDS, 784: depth of the weight storage in 32-bit words.
- CNT_W, $clog2(NUM_WORDS+1): width of the word counter and of words_loaded.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: single-cycle pulse that begins a load at word 0.
- abort, input, 1: cancels an in-progress load.
- in_valid, input, 1: in_byte is valid this cycle.
- in_byte, input, 8: stream byte.
- in_ready, output, 1: loader accepts a byte this cycle.
- busy, output, 1: high while in state LOAD.
- done, output, 1: high once all NUM_WORDS words are written; held until the next start, abort or rst.
- overrun, output, 1: sticky flag; in_valid was seen while in DONE.
- words_loaded, output, CNT_W: count of complete words written in the current load.
- read_add, input, 32: read word address.
- write_out, output, 32: mem[read_add]; 0 when read_add >= NUM_WORDS.

Behaviour:
- Reset (async, active-high): state IDLE; in_ready, busy, done and overrun are 0; words_loaded, byte_cnt and the assembly register are 0. Storage contents are NOT reset.
- States and transitions:
  - IDLE: start moves to LOAD.
  - LOAD: writing the final word moves to DONE; abort moves to IDLE.
  - DONE: start moves to LOAD; abort moves to IDLE.
- On entering LOAD:
  - words_loaded, byte_cnt and the assembly register clear to 0.
  - done and overrun clear to 0.
- in_ready = 1 only in LOAD. It is combinational from state and is 0 in the cycle after the final word is written.
- Byte acceptance, when in_valid && in_ready:
  - byte_cnt 0, 1, 2: the byte goes to bits [7:0], [15:8], [23:16] of the assembly register respectively.
  - byte_cnt 3: mem[words_loaded] <= {in_byte, asm[23:0]} on the same edge. words_loaded increments and byte_cnt wraps to 0.
- Final word: the write with words_loaded == NUM_WORDS-1 sets state DONE and done = 1 on that same edge; words_loaded becomes NUM_WORDS.
- start while in LOAD is ignored.
- abort while in LOAD:
  - Discards the partial word.
  - Words already written stay in memory.
  - words_loaded holds its value; done stays 0.
- Simultaneous start and abort: abort wins.
- in_valid while in IDLE: no effect, no flag.
- in_valid while in DONE: overrun <= 1; the byte is dropped.
- Read port:
  - Purely combinational, zero latency.
  - A read of the address being written in the same cycle returns the old contents; the new value is visible the cycle after the edge.
  - Out-of-range address returns 32'h0.
- Async reset mid-LOAD: returns to IDLE immediately; already written words persist.

Decomposition:
- Shared package holds:
  - WORD_W = 32 and BYTE_W = 8.
  - The state enum {IDLE, LOAD, DONE}.
  - Default NUM_WORDS values per layer (784 input layer, hidden-layer sizes).
- One natural sub-module: weight_ram. It has a synchronous write port and an asynchronous read port with the out-of-range-returns-0 rule. weight_loader instantiates it alongside the FSM and the byte assembler.

Test Plan:
- Reset then idle: rst pulse, then read_add = 0 → in_ready = 0, busy = 0, done = 0, words_loaded = 0; in_valid with no start leaves words_loaded = 0.
- Full load with NUM_WORDS = 4: start, then 16 bytes 0x01..0x10 back-to-back →
  - mem[0] = 32'h04030201 and mem[3] = 32'h100F0E0D.
  - done rises on the 16th accepted byte's edge; words_loaded = 4; in_ready drops.
- Gapped handshake: in_valid toggled every other cycle during the same load → identical memory contents; bytes offered while in_valid = 0 are not counted.
- Abort mid-word: start, 6 bytes, then abort →
  - State IDLE; words_loaded = 1; mem[1] unchanged.
  - A subsequent start and a full load overwrite it correctly.
- Overrun and boundaries:
  - After done, in_valid with 0xAA → overrun = 1 and memory unchanged.
  - read_add = NUM_WORDS returns 0.
  - start in DONE restarts the load and clears done and overrun.
- Reset mid-load: rst asserted asynchronously between clock edges after 2 words → busy = 0 immediately; mem[0] and mem[1] are retained; reads still work.
